// File: rtl/rf_pkg.sv
// Shared register-file constants and the writeback source selector used by
// both the writeback stage and the EX forwarding unit.
package rf_pkg;

   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;
   localparam int DATA_W    = 32;

   localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      WB_SRC_ALU  = 2'd0,
      WB_SRC_MEM  = 2'd1,
      WB_SRC_LINK = 2'd2
   } wb_src_e;

   // A call's link address outranks load data, which outranks the ALU result.
   function automatic wb_src_e wb_src_of(input logic call, input logic mem_read);
      if (call)
         return WB_SRC_LINK;
      else if (mem_read)
         return WB_SRC_MEM;
      else
         return WB_SRC_ALU;
   endfunction

endpackage

// File: rtl/wb_select.sv
// Writeback value mux: link address, load data or ALU result, in that priority.
module wb_select
   import rf_pkg::*;
#(
   parameter int W = rf_pkg::DATA_W
) (
   input  logic         call,
   input  logic         mem_read,
   input  logic [W-1:0] npc,
   input  logic [W-1:0] mem_data,
   input  logic [W-1:0] alu_result,
   output logic [W-1:0] wb_value
);

   // NOTE: assign a default before any branch so no path leaves the output
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      wb_value = alu_result;
      unique case (wb_src_of(call, mem_read))
         WB_SRC_LINK: wb_value = npc;
         WB_SRC_MEM:  wb_value = mem_data;
         default:     wb_value = alu_result;
      endcase
   end

endmodule

// File: rtl/writeback_register_file.sv
// MEM/WB consumer: commits the selected writeback value to a 32x32 register
// file, serves two bypassed read ports, and keeps a last-write record and counter.
module writeback_register_file
   import rf_pkg::REG_IDX_W;
   import rf_pkg::REG_ZERO;
#(
   parameter int DATA_W   = rf_pkg::DATA_W,
   parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 WB,
   input  logic                 MEM_Read,
   input  logic                 CALL,
   input  logic [DATA_W-1:0]    npc,
   input  logic [DATA_W-1:0]    MEM_Data,
   input  logic [DATA_W-1:0]    ALU_result,
   input  logic [REG_IDX_W-1:0] R_dest,
   input  logic [REG_IDX_W-1:0] rs1_addr,
   input  logic [REG_IDX_W-1:0] rs2_addr,
   output logic [DATA_W-1:0]    rs1_data,
   output logic [DATA_W-1:0]    rs2_data,
   output logic                 fwd_valid,
   output logic [REG_IDX_W-1:0] fwd_rd,
   output logic [DATA_W-1:0]    fwd_data,
   output logic [31:0]          wb_count
);

   logic [DATA_W-1:0] wb_value;
   logic              we;

   logic [DATA_W-1:0] regs [NUM_REGS];

   logic                 fwd_valid_q;
   logic [REG_IDX_W-1:0] fwd_rd_q;
   logic [DATA_W-1:0]    fwd_data_q;
   logic [31:0]          wb_count_q;

   wb_select #(
      .W(DATA_W)
   ) u_wb_select (
      .call       (CALL),
      .mem_read   (MEM_Read),
      .npc        (npc),
      .mem_data   (MEM_Data),
      .alu_result (ALU_result),
      .wb_value   (wb_value)
   );

   // R0 is hardwired to zero, so a write aimed at it is not a write at all.
   assign we = WB && (R_dest != REG_ZERO);

   // NOTE: the array is built from flops rather than RAM so it can be cleared
   // by the asynchronous reset; a RAM macro could not be reset this way.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (we) begin
         regs[R_dest] <= wb_value;
      end
   end

   // Read ports: R0 reads zero; a same-cycle write to the addressed register
   // is visible immediately through the bypass.
   always_comb begin
      rs1_data = regs[rs1_addr];
      if (rs1_addr == REG_ZERO)
         rs1_data = '0;
      else if (we && (rs1_addr == R_dest))
         rs1_data = wb_value;
   end

   always_comb begin
      rs2_data = regs[rs2_addr];
      if (rs2_addr == REG_ZERO)
         rs2_data = '0;
      else if (we && (rs2_addr == R_dest))
         rs2_data = wb_value;
   end

   // One-entry record of the write committed on the most recent edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fwd_valid_q <= 1'b0;
         fwd_rd_q    <= REG_ZERO;
         fwd_data_q  <= '0;
      end else begin
         fwd_valid_q <= we;
         fwd_rd_q    <= we ? R_dest : REG_ZERO;
         fwd_data_q  <= we ? wb_value : '0;
      end
   end

   // Retired-write counter; wraps silently, and a held write counts every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wb_count_q <= '0;
      else if (we)
         wb_count_q <= wb_count_q + 32'd1;
   end

   assign fwd_valid = fwd_valid_q;
   assign fwd_rd    = fwd_rd_q;
   assign fwd_data  = fwd_data_q;
   assign wb_count  = wb_count_q;

endmodule

// File: tb/tb_writeback_register_file.sv
// Directed bench for writeback_register_file: one task per feature, hand-computed expectations.
module tb_writeback_register_file;

   logic        clk;
   logic        reset;
   logic        WB;
   logic        MEM_Read;
   logic        CALL;
   logic [31:0] npc;
   logic [31:0] MEM_Data;
   logic [31:0] ALU_result;
   logic [4:0]  R_dest;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic [31:0] wb_count;

   int total  = 0;
   int passed = 0;

   writeback_register_file dut (
      .clk        (clk),
      .reset      (reset),
      .WB         (WB),
      .MEM_Read   (MEM_Read),
      .CALL       (CALL),
      .npc        (npc),
      .MEM_Data   (MEM_Data),
      .ALU_result (ALU_result),
      .R_dest     (R_dest),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .fwd_valid  (fwd_valid),
      .fwd_rd     (fwd_rd),
      .fwd_data   (fwd_data),
      .wb_count   (wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic wb, input logic mem_read, input logic call,
                        input logic [31:0] pc1, input logic [31:0] mem,
                        input logic [31:0] alu, input logic [4:0] rd);
      WB = wb; MEM_Read = mem_read; CALL = call;
      npc = pc1; MEM_Data = mem; ALU_result = alu; R_dest = rd;
   endtask

   task automatic bubble();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
   endtask

   // Commit one ALU write across one edge; returns at the following negedge with a bubble applied.
   task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, val, rd);
      @(posedge clk);
      @(negedge clk);
      bubble();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bubble();
      rs1_addr = 5'd0; rs2_addr = 5'd0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(31 - i);
         #1;
         total++; if (rs1_data !== 32'h0) $display("FAIL reset_rs1[%0d]: got %h want 0", i, rs1_data); else passed++;
         total++; if (rs2_data !== 32'h0) $display("FAIL reset_rs2[%0d]: got %h want 0", 31 - i, rs2_data); else passed++;
      end
      total++; if (wb_count !== 32'h0) $display("FAIL reset_count: got %h want 0", wb_count); else passed++;
      total++; if (fwd_valid !== 1'b0) $display("FAIL reset_fwd_valid: got %b want 0", fwd_valid); else passed++;
      total++; if (fwd_rd !== 5'd0) $display("FAIL reset_fwd_rd: got %0d want 0", fwd_rd); else passed++;
      total++; if (fwd_data !== 32'h0) $display("FAIL reset_fwd_data: got %h want 0", fwd_data); else passed++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_alu_write();
      write_reg(5'd5, 32'h0000_1234);
      rs1_addr = 5'd5; rs2_addr = 5'd6;
      #1;
      total++; if (rs1_data !== 32'h0000_1234) $display("FAIL alu_r5: got %h want 00001234", rs1_data); else passed++;
      total++; if (rs2_data !== 32'h0) $display("FAIL alu_r6_untouched: got %h want 0", rs2_data); else passed++;
      total++; if (fwd_valid !== 1'b1) $display("FAIL alu_fwd_valid: got %b want 1", fwd_valid); else passed++;
      total++; if (fwd_rd !== 5'd5) $display("FAIL alu_fwd_rd: got %0d want 5", fwd_rd); else passed++;
      total++; if (fwd_data !== 32'h0000_1234) $display("FAIL alu_fwd_data: got %h want 00001234", fwd_data); else passed++;
      total++; if (wb_count !== 32'd1) $display("FAIL alu_count: got %0d want 1", wb_count); else passed++;
   endtask

   task automatic test_priority();
      drive(1'b1, 1'b1, 1'b1, 32'h40, 32'hAA, 32'h55, 5'd31);
      @(posedge clk);
      @(negedge clk);
      bubble();
      rs2_addr = 5'd31;
      #1;
      total++; if (rs2_data !== 32'h40) $display("FAIL prio_call_wins: got %h want 00000040", rs2_data); else passed++;
      total++; if (fwd_data !== 32'h40) $display("FAIL prio_call_fwd: got %h want 00000040", fwd_data); else passed++;
      drive(1'b1, 1'b1, 1'b0, 32'h40, 32'hAA, 32'h55, 5'd31);
      @(posedge clk);
      @(negedge clk);
      bubble();
      #1;
      total++; if (rs2_data !== 32'hAA) $display("FAIL prio_mem_wins: got %h want 000000aa", rs2_data); else passed++;
      total++; if (wb_count !== 32'd3) $display("FAIL prio_count: got %0d want 3", wb_count); else passed++;
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hA0A0_0001, 5'd10);
      @(posedge clk);
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hB0B0_0002, 5'd11);
      rs1_addr = 5'd10; rs2_addr = 5'd11;
      #1;
      total++; if (rs1_data !== 32'hA0A0_0001) $display("FAIL b2b_r10_array: got %h want a0a00001", rs1_data); else passed++;
      total++; if (rs2_data !== 32'hB0B0_0002) $display("FAIL b2b_r11_bypass: got %h want b0b00002", rs2_data); else passed++;
      total++; if (fwd_rd !== 5'd10) $display("FAIL b2b_fwd_rd_first: got %0d want 10", fwd_rd); else passed++;
      @(posedge clk);
      @(negedge clk);
      bubble();
      #1;
      total++; if (fwd_rd !== 5'd11) $display("FAIL b2b_fwd_rd_second: got %0d want 11", fwd_rd); else passed++;
      total++; if (fwd_data !== 32'hB0B0_0002) $display("FAIL b2b_fwd_data: got %h want b0b00002", fwd_data); else passed++;
      total++; if (wb_count !== 32'd5) $display("FAIL b2b_count: got %0d want 5", wb_count); else passed++;
   endtask

   task automatic test_bypass();
      write_reg(5'd7, 32'h0000_1111);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_BEEF, 5'd7);
      rs1_addr = 5'd7; rs2_addr = 5'd7;
      #1;
      total++; if (rs1_data !== 32'h0000_BEEF) $display("FAIL bypass_rs1: got %h want 0000beef", rs1_data); else passed++;
      total++; if (rs2_data !== 32'h0000_BEEF) $display("FAIL bypass_rs2: got %h want 0000beef", rs2_data); else passed++;
      total++; if (dut.regs[7] !== 32'h0000_1111) $display("FAIL bypass_array_old: got %h want 00001111", dut.regs[7]); else passed++;
      rs2_addr = 5'd5;
      #1;
      total++; if (rs2_data !== 32'h0000_1234) $display("FAIL bypass_other_port: got %h want 00001234", rs2_data); else passed++;
      @(posedge clk);
      @(negedge clk);
      bubble();
      #1;
      total++; if (rs1_data !== 32'h0000_BEEF) $display("FAIL bypass_committed: got %h want 0000beef", rs1_data); else passed++;
      total++; if (wb_count !== 32'd7) $display("FAIL bypass_count: got %0d want 7", wb_count); else passed++;
   endtask

   task automatic test_r0_and_bubble();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_FFFF, 5'd0);
      rs1_addr = 5'd0; rs2_addr = 5'd0;
      #1;
      total++; if (rs1_data !== 32'h0) $display("FAIL r0_bypass_blocked: got %h want 0", rs1_data); else passed++;
      @(posedge clk);
      @(negedge clk);
      bubble();
      #1;
      total++; if (rs2_data !== 32'h0) $display("FAIL r0_reads_zero: got %h want 0", rs2_data); else passed++;
      total++; if (dut.regs[0] !== 32'h0) $display("FAIL r0_array: got %h want 0", dut.regs[0]); else passed++;
      total++; if (fwd_valid !== 1'b0) $display("FAIL r0_fwd_valid: got %b want 0", fwd_valid); else passed++;
      total++; if (wb_count !== 32'd7) $display("FAIL r0_count: got %0d want 7", wb_count); else passed++;
      write_reg(5'd3, 32'h33);
      @(posedge clk);
      @(negedge clk);
      rs1_addr = 5'd3;
      #1;
      total++; if (fwd_valid !== 1'b0) $display("FAIL bubble_fwd_valid: got %b want 0", fwd_valid); else passed++;
      total++; if (fwd_data !== 32'h0) $display("FAIL bubble_fwd_data: got %h want 0", fwd_data); else passed++;
      total++; if (wb_count !== 32'd8) $display("FAIL bubble_count: got %0d want 8", wb_count); else passed++;
      total++; if (rs1_data !== 32'h33) $display("FAIL bubble_r3_held: got %h want 00000033", rs1_data); else passed++;
   endtask

   task automatic test_reset_mid_write();
      write_reg(5'd1, 32'h11);
      write_reg(5'd2, 32'h22);
      write_reg(5'd3, 32'h33);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h44, 5'd4);
      rs1_addr = 5'd1; rs2_addr = 5'd2;
      #1;
      total++; if (rs1_data !== 32'h11) $display("FAIL mid_pre_r1: got %h want 00000011", rs1_data); else passed++;
      total++; if (wb_count !== 32'd11) $display("FAIL mid_pre_count: got %0d want 11", wb_count); else passed++;
      #1 reset = 1'b1;
      #1;
      total++; if (rs1_data !== 32'h0) $display("FAIL mid_r1_cleared: got %h want 0", rs1_data); else passed++;
      total++; if (rs2_data !== 32'h0) $display("FAIL mid_r2_cleared: got %h want 0", rs2_data); else passed++;
      total++; if (dut.regs[3] !== 32'h0) $display("FAIL mid_r3_cleared: got %h want 0", dut.regs[3]); else passed++;
      total++; if (fwd_valid !== 1'b0) $display("FAIL mid_fwd_valid: got %b want 0", fwd_valid); else passed++;
      total++; if (fwd_rd !== 5'd0) $display("FAIL mid_fwd_rd: got %0d want 0", fwd_rd); else passed++;
      total++; if (wb_count !== 32'd0) $display("FAIL mid_count: got %0d want 0", wb_count); else passed++;
      @(posedge clk);
      @(negedge clk);
      bubble();
      rs1_addr = 5'd4;
      #1;
      total++; if (rs1_data !== 32'h0) $display("FAIL mid_write_dropped: got %h want 0", rs1_data); else passed++;
      total++; if (wb_count !== 32'd0) $display("FAIL mid_count_held: got %0d want 0", wb_count); else passed++;
      reset = 1'b0;
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force dut.wb_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.wb_count_q;
      write_reg(5'd9, 32'h99);
      rs1_addr = 5'd9;
      #1;
      total++; if (wb_count !== 32'h0) $display("FAIL wrap_count: got %h want 0", wb_count); else passed++;
      total++; if (rs1_data !== 32'h99) $display("FAIL wrap_r9: got %h want 00000099", rs1_data); else passed++;
   endtask

   initial begin
      reset = 1'b1;
      WB = 1'b0; MEM_Read = 1'b0; CALL = 1'b0;
      npc = '0; MEM_Data = '0; ALU_result = '0; R_dest = '0;
      rs1_addr = '0; rs2_addr = '0;
      test_reset();
      test_alu_write();
      test_priority();
      test_back_to_back();
      test_bypass();
      test_r0_and_bubble();
      test_reset_mid_write();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/writeback_register_file.md
# writeback_register_file

Consumer end of the MEM/WB buffer: takes the registered MEM/WB fields, selects the writeback value, and commits it to a 32×32 general-purpose register file. It also serves two combinational read ports to decode, with same-cycle write-through bypass. A registered one-entry forwarding record of the last committed write is kept for the EX-stage forwarding unit, along with a retired-write counter.

## Interface
Parameters:
- DATA_W, 32, register/data width
- NUM_REGS, 32, register count (index width 5)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- WB  in  1  MEM/WB write-back enable
- MEM_Read  in  1  result comes from memory
- CALL  in  1  result is link address
- npc  in  32  link address (PC+1 of the call)
- MEM_Data  in  32  load data
- ALU_result  in  32  ALU output
- R_dest  in  5  destination register
- rs1_addr, rs2_addr  in  5 each  decode read addresses
- rs1_data, rs2_data  out  32 each  decode read data (combinational)
- fwd_valid  out  1  last-cycle write record valid
- fwd_rd  out  5  last written register
- fwd_data  out  32  last written value
- wb_count  out  32  number of committed register writes

## Operation
- Writeback value (priority order): CALL → npc; else MEM_Read → MEM_Data; else ALU_result.
- Write enable: we = WB && (R_dest != 0). R0 is never written and always reads 0.
- On posedge clk with we: regs[R_dest] <= selected value.
- Read ports, per port:
  - addr == 0 → 0.
  - addr == R_dest && we → the selected writeback value (bypass).
  - otherwise → regs[addr].
- Forward record, on every posedge:
  - fwd_valid <= we.
  - fwd_rd <= we ? R_dest : 0.
  - fwd_data <= we ? selected value : 0.
- Counter: wb_count increments by 1 on each posedge with we. Wraps 0xFFFFFFFF → 0 with no flag.
- A bubble arriving from MEM/WB (all fields zero) produces no write: fwd_valid goes 0 and the counter holds.
- The block has no stall input. The upstream buffer holds its outputs during a stall, so a held WB=1 rewrites the same value. That write is idempotent, but it is counted once per cycle.

## Timing
- Reset (asynchronous assert, released synchronously by the surrounding logic):
  - all regs = 0
  - fwd_valid = 0, fwd_rd = 0, fwd_data = 0
  - wb_count = 0
  - Because rs*_data are combinational, they read 0 during reset unless the bypass path is active.
- Write latency: 1 cycle into the array. A read in the same cycle sees the new value through the bypass.
- The forward record is valid for exactly one cycle after the commit.
- Reset asserted mid-write: the write is dropped, and the array and counter clear immediately.
- rs1_addr == rs2_addr == R_dest with we: both ports return the bypassed value.
- R_dest = 0 with WB = 1: no write, no count, fwd_valid = 0, and reads of R0 still return 0.

## Structure
- Shared package rf_pkg: REG_IDX_W=5, NUM_REGS=32, DATA_W=32, REG_ZERO=5'd0.
- Sub-module wb_select (combinational 3:1 priority mux: CALL, MEM_Read, ALU). It is reused by the EX forwarding unit.
- The array is plain flops, not inferred RAM, because it needs an asynchronous clear and two asynchronous read ports.

## Test plan
- Reset, then read all 32 registers → all 0; wb_count=0; fwd_valid=0.
- WB=1, R_dest=5, ALU_result=0x1234, clock; then read rs1=5 → 0x1234; fwd_valid=1, fwd_rd=5, fwd_data=0x1234; wb_count=1.
- WB=1, MEM_Read=1, CALL=1, npc=0x40, MEM_Data=0xAA, R_dest=31 → r31=0x40 (CALL wins). Then MEM_Read=1 only, MEM_Data=0xAA → r31=0xAA.
- Same-cycle bypass: WB=1, R_dest=7, ALU_result=0xBEEF, rs1=rs2=7, checked before the edge → both read 0xBEEF while regs[7] is still old.
- WB=1, R_dest=0, ALU_result=0xFFFF → r0 reads 0, fwd_valid=0, wb_count unchanged. An all-zero bubble likewise gives no change.
- Load regs via 3 writes, assert reset mid-cycle while WB=1 → regs, fwd_* and wb_count read 0 immediately. Separately, force wb_count=0xFFFFFFFF and do one write → wb_count=0.
